// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder.
package i2c_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic       I2C_ACK        = 1'b0;
  localparam logic       I2C_NACK       = 1'b1;
  localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus edge, START and STOP detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i2c_scl,
  input  logic i2c_sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Synchronizer chains plus one delay flop; reset to the idle-bus level so no false edges appear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C responder: address match, byte write to local logic, byte read from local logic.
// Optional macro I2C_SLAVE_GCALL_EN: ACK general-call writes to address 7'h00.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       tx_sh, tx_sh_n;
  logic             rw, rw_n;
  logic             sda_n;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n, tx_req_n, busy_n;
  logic             addr_hit;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i2c_scl   (i2c_scl),
    .i2c_sda_i (i2c_sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

`ifdef I2C_SLAVE_GCALL_EN
  assign addr_hit = (shift[7:1] == SLAVE_ADDR) ||
                    ((shift[7:1] == I2C_GCALL_ADDR) && (shift[0] == 1'b0));
`else
  assign addr_hit = (shift[7:1] == SLAVE_ADDR);
`endif

  // State and output registers; reset releases SDA immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      tx_sh     <= '0;
      rw        <= 1'b0;
      i2c_sda_o <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      tx_sh     <= tx_sh_n;
      rw        <= rw_n;
      i2c_sda_o <= sda_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output logic; bus conditions win over bit processing
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_n    = shift;
    tx_sh_n    = tx_sh;
    rw_n       = rw;
    sda_n      = i2c_sda_o;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;

    if (stop_det) begin
      state_n = IDLE;
      cnt_n   = '0;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + CNT_W'(1);
          end else if (scl_fall && cnt == CNT_W'(8)) begin
            if (addr_hit) begin
              sda_n   = I2C_ACK;
              busy_n  = 1'b1;
              rw_n    = shift[0];
              state_n = ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_n   = 1'b1;
              cnt_n   = '0;
              state_n = WRITE;
            end else begin
              sda_n    = tx_data[7];
              tx_sh_n  = {tx_data[6:0], 1'b0};
              tx_req_n = 1'b1;
              cnt_n    = CNT_W'(1);
              state_n  = READ;
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              rx_data_n  = {shift[6:0], sda_s};
              rx_valid_n = 1'b1;
            end
          end else if (scl_fall && cnt == CNT_W'(8)) begin
            sda_n   = I2C_ACK;
            state_n = WRITE_ACK;
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            sda_n   = 1'b1;
            cnt_n   = '0;
            state_n = WRITE;
          end
        end
        READ: begin
          if (scl_fall) begin
            if (cnt == CNT_W'(8)) begin
              sda_n   = 1'b1;
              state_n = READ_ACK;
            end else begin
              sda_n   = tx_sh[7];
              tx_sh_n = {tx_sh[6:0], 1'b0};
              cnt_n   = cnt + CNT_W'(1);
            end
          end
        end
        READ_ACK: begin
          if (scl_rise && sda_s == I2C_NACK) begin
            busy_n  = 1'b0;
            state_n = WAIT_STOP;
          end else if (scl_fall) begin
            sda_n    = tx_data[7];
            tx_sh_n  = {tx_data[6:0], 1'b0};
            tx_req_n = 1'b1;
            cnt_n    = CNT_W'(1);
            state_n  = READ;
          end
        end
        WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the opposite end of the bus from the team's i2c_master.
- Oversamples the bus on the system clock, detects START, repeated START and STOP, and matches a 7-bit address.
- Write transactions: shifts in data bytes and presents them to local logic.
- Read transactions: fetches bytes from local logic and shifts them out, with per-byte ACK/NACK on the bus.

Parameters:
- SLAVE_ADDR, 7'h50: 7-bit bus address this responder answers to.
- SYNC_STAGES, 2: flop stages in the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; frequency must be at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- i2c_scl  input  1  bus clock from the master.
- i2c_sda_i  input  1  bus data as seen on the wire.
- i2c_sda_o  output  1  open-drain drive: 0 pulls SDA low, 1 releases it.
- rx_data  output  8  last byte received in a write transaction.
- rx_valid  output  1  one-clk pulse; rx_data has just been updated.
- tx_data  input  8  next byte to send in a read transaction; must be stable whenever tx_req is low.
- tx_req  output  1  one-clk pulse; tx_data has been latched, present the next byte.
- busy  output  1  high from an addressed START until STOP, NACK or mismatch.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - i2c_sda_o=1, rx_data=0, rx_valid=0, tx_req=0, busy=0, state=IDLE.
  - Shift register and bit counter cleared.
  - If reset is asserted mid-transfer, SDA is released at once.
- Input conditioning:
  - i2c_scl and i2c_sda_i pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - START = synced SDA falls while synced SCL is high.
  - STOP = synced SDA rises while synced SCL is high.
  - All internal decisions use the synced signals.
- Bit timing:
  - The receiver samples SDA on a synced SCL rising edge; bits are MSB first.
  - The responder changes i2c_sda_o only in the clk after a synced SCL falling edge.
- States (3-bit enum): IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
  - IDLE: on START, go to ADDR and clear the bit counter.
  - ADDR: shift in 8 bits (7 address bits, then R/W).
    - On the falling edge after bit 8: if address == SLAVE_ADDR, drive i2c_sda_o=0, set busy=1, go to ADDR_ACK.
    - Otherwise keep SDA released and go to WAIT_STOP.
  - ADDR_ACK: on the falling edge ending the 9th clock:
    - R/W=0: release SDA, go to WRITE.
    - R/W=1: latch tx_data, pulse tx_req, drive bit 7, go to READ.
  - WRITE: shift in 8 bits.
    - After the 8th sample, rx_data updates and rx_valid pulses in the following clk.
    - On the next falling edge, drive ACK (0) and go to WRITE_ACK.
  - WRITE_ACK: on the falling edge, release SDA and return to WRITE.
  - READ: drive bits 7..0 on successive falling edges. After the 8th bit's falling edge, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the rising edge.
    - 0 (master ACK): on the falling edge, latch tx_data, pulse tx_req, drive bit 7, go to READ.
    - 1 (master NACK): keep SDA released, busy=0, go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore everything except START/STOP.
- Priority:
  - START detected in any state (repeated START) goes to ADDR with the counter cleared and SDA released. A partial byte is discarded with no rx_valid.
  - STOP detected in any state goes to IDLE with SDA released and busy=0.
  - START and STOP take priority over bit processing in the same clk.
- Pulse rules: rx_valid and tx_req are never asserted together and are never high for more than one clk.

Optional Feature:
- Macro I2C_SLAVE_GCALL_EN.
- Defined: address 7'h00 with R/W=0 (general call) is ACKed and handled as a write; 7'h00 with R/W=1 is NACKed and goes to WAIT_STOP.
- Undefined: address 7'h00 is treated as a mismatch and NACKed.

Decomposition:
- Package i2c_pkg:
  - Responder state enum.
  - Constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_GCALL_ADDR=7'h00.
- Sub-module i2c_line_sync:
  - Synchronizers, edge detection.
  - Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write, SLAVE_ADDR=0x50: START, 0xA0, then 0x3C, then STOP.
  - i2c_sda_o=0 during both 9th clocks.
  - rx_data=0x3C with exactly one rx_valid pulse.
  - busy high from the address ACK until STOP.
- Address mismatch: START, 0xA2.
  - i2c_sda_o stays 1 throughout; no rx_valid; busy stays 0.
  - The next START with 0xA0 is ACKed.
- Read: START, 0xA1, with tx_data=0x96 then 0x5A; master ACKs the first byte and NACKs the second.
  - SDA carries 1,0,0,1,0,1,1,0, then 0,1,0,1,1,0,1,0.
  - tx_req pulses twice; SDA is released after the NACK; state is WAIT_STOP until STOP.
- Repeated START after 3 bits of a write data byte.
  - No rx_valid; the new address 0xA1 is ACKed and a read proceeds.
- Reset asserted while driving a 0 data bit in READ.
  - i2c_sda_o=1 within the same cycle; all outputs return to reset values; state is IDLE.
- General call, START then 0x00.
  - With I2C_SLAVE_GCALL_EN: ACKed and a following 0x11 produces rx_valid.
  - Without the macro: NACKed.
